// File: rtl/test_result_monitor.sv
// ---------------------------------------------------------------------------
// test_result_monitor
//
// End-of-test detector for the pipelined Core. It snoops the writeback stream
// to keep a shadow copy of the test-status register (gp). It also watches the
// fetch PC for the end-of-test handler address. Once that address is fetched,
// it waits a fixed number of cycles for the pipeline to drain and then latches
// a sticky verdict: pass, fail or timeout.
//
// Ports
//   clk           in   1   system clock, rising edge
//   rst           in   1   synchronous reset, active low
//   if_pc         in  32   fetch-stage PC
//   wb_en         in   1   register-file write enable (writeback stage)
//   wb_rd         in   5   writeback destination register
//   wb_data       in  32   writeback data
//   done          out  1   a verdict has been latched
//   pass          out  1   gp == 1 at evaluation
//   fail          out  1   gp != 1 at evaluation
//   timeout       out  1   cycle budget ran out before a verdict
//   fail_testnum  out 31   gp[31:1] at evaluation, 0 unless fail
//   cycle_count   out 32   cycles spent in RUN+DRAIN, frozen at the verdict
//   retire_count  out 32   (MONITOR_RETIRE_CNT_EN only) writeback cycles in
//                          RUN+DRAIN, saturating, frozen at the verdict
//
// Optional feature macro: MONITOR_RETIRE_CNT_EN
// ---------------------------------------------------------------------------
module test_result_monitor #(
    parameter logic [31:0] END_PC       = 32'h44,
    parameter int unsigned DRAIN_CYCLES = 4,      // legal range 1..15
    parameter int unsigned MAX_CYCLES   = 6000,   // must be < 2^32
    parameter logic [4:0]  GP_REG       = 5'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [30:0] fail_testnum,
    output logic [31:0] cycle_count
`ifdef MONITOR_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_count
`endif
);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [3:0]  DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [31:0] CYCLE_LAST = 32'(MAX_CYCLES - 1);

    state_t      state;
    logic [31:0] shadow_gp;
    logic [3:0]  drain_cnt;

    logic        gp_write;
    logic [31:0] gp_eval;
    logic        budget_hit;
    logic        drain_last;

    // x0 is hardwired to zero in the Core, so a write to it never updates the
    // shadow, even if GP_REG is configured as 0.
    assign gp_write   = wb_en && (wb_rd == GP_REG) && (wb_rd != 5'd0);
    // Bypass: a gp write landing on the evaluating edge is the value judged.
    assign gp_eval    = gp_write ? wb_data : shadow_gp;
    assign budget_hit = (cycle_count == CYCLE_LAST);
    assign drain_last = (drain_cnt == DRAIN_LAST);

    // NOTE: every register here is assigned with <= so that all of them sample
    // the pre-edge values; blocking assignments would let later statements see
    // already-updated state and desynchronise the counters from the FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_RUN;
            shadow_gp    <= '0;
            drain_cnt    <= '0;
            cycle_count  <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            fail_testnum <= '0;
`ifdef MONITOR_RETIRE_CNT_EN
            retire_count <= '0;
`endif
        end else begin
            unique case (state)
                S_RUN, S_DRAIN: begin
                    cycle_count <= cycle_count + 32'd1;
                    if (gp_write) begin
                        shadow_gp <= wb_data;
                    end
`ifdef MONITOR_RETIRE_CNT_EN
                    if (wb_en && (retire_count != 32'hFFFF_FFFF)) begin
                        retire_count <= retire_count + 32'd1;
                    end
`endif
                    if (state == S_RUN) begin
                        // Entering DRAIN is not a verdict, so the budget
                        // takes priority over an END_PC fetch here.
                        if (budget_hit) begin
                            state   <= S_TIMEOUT;
                            done    <= 1'b1;
                            timeout <= 1'b1;
                        end else if (if_pc == END_PC) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end else begin
                        // Drain is committed: if_pc is not looked at here.
                        // A drain verdict beats a same-edge budget expiry.
                        if (drain_last) begin
                            done <= 1'b1;
                            if (gp_eval == 32'd1) begin
                                state <= S_PASS;
                                pass  <= 1'b1;
                            end else begin
                                state        <= S_FAIL;
                                fail         <= 1'b1;
                                fail_testnum <= gp_eval[31:1];
                            end
                        end else if (budget_hit) begin
                            state   <= S_TIMEOUT;
                            done    <= 1'b1;
                            timeout <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 4'd1;
                        end
                    end
                end
                // Terminal states hold everything until reset.
                S_PASS, S_FAIL, S_TIMEOUT: begin
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_result_monitor.sv
module tb_test_result_monitor;

    localparam logic [31:0] END_PC  = 32'h44;
    localparam logic [31:0] IDLE_PC = 32'h100;
    localparam int          DRAIN   = 4;
    localparam int          MAXC    = 50;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [30:0] fail_testnum;
    logic [31:0] cycle_count;
`ifdef MONITOR_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    test_result_monitor #(
        .END_PC      (END_PC),
        .DRAIN_CYCLES(DRAIN),
        .MAX_CYCLES  (MAXC),
        .GP_REG      (5'd3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_pc       (if_pc),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .fail_testnum(fail_testnum),
        .cycle_count (cycle_count)
`ifdef MONITOR_RETIRE_CNT_EN
        ,
        .retire_count(retire_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pass;
        logic        fail;
        logic        timeout;
        logic [30:0] testnum;
        logic [31:0] cycles;
        logic [31:0] retire;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;   // edges since reset release

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_rd   = rd;
        wb_data = data;
        tick();
        wb_en   = 1'b0;
        wb_rd   = 5'd0;
        wb_data = 32'd0;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        wb_en = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic push_exp(input logic p, input logic f, input logic t,
                            input logic [30:0] tn, input int cycles, input int retire);
        exp_t e;
        e.pass    = p;
        e.fail    = f;
        e.timeout = t;
        e.testnum = tn;
        e.cycles  = 32'(cycles);
        e.retire  = 32'(retire);
        sb.push_back(e);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " done"},    {31'd0, done},    32'd0);
        check({tag, " pass"},    {31'd0, pass},    32'd0);
        check({tag, " fail"},    {31'd0, fail},    32'd0);
        check({tag, " timeout"}, {31'd0, timeout}, 32'd0);
        check({tag, " testnum"}, {1'b0, fail_testnum}, 32'd0);
        check({tag, " cycles"},  cycle_count,      32'd0);
`ifdef MONITOR_RETIRE_CNT_EN
        check({tag, " retire"},  retire_count,     32'd0);
`endif
    endtask

    // Waits for done, pops the expected verdict, compares it, then hammers
    // the inputs for a few cycles to confirm the verdict stays frozen.
    task automatic expect_verdict(input string tag, input int budget);
        exp_t e;
        int   waited = 0;
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        while (!done && waited < budget) begin
            tick();
            waited++;
        end
        if (!done) begin
            check({tag, " verdict wait expired"}, {31'd0, done}, 32'd1);
            return;
        end
        check({tag, " verdict edge"}, 32'(cyc),            e.cycles);
        check({tag, " pass"},         {31'd0, pass},       {31'd0, e.pass});
        check({tag, " fail"},         {31'd0, fail},       {31'd0, e.fail});
        check({tag, " timeout"},      {31'd0, timeout},    {31'd0, e.timeout});
        check({tag, " testnum"},      {1'b0, fail_testnum}, {1'b0, e.testnum});
        check({tag, " cycles"},       cycle_count,         e.cycles);
`ifdef MONITOR_RETIRE_CNT_EN
        check({tag, " retire"},       retire_count,        e.retire);
`endif
        if_pc   = END_PC;
        wb_en   = 1'b1;
        wb_rd   = 5'd3;
        wb_data = 32'd1;
        idle(3);
        wb_en   = 1'b0;
        wb_rd   = 5'd0;
        wb_data = 32'd0;
        if_pc   = IDLE_PC;
        check({tag, " frozen done"},    {31'd0, done},        32'd1);
        check({tag, " frozen pass"},    {31'd0, pass},        {31'd0, e.pass});
        check({tag, " frozen timeout"}, {31'd0, timeout},     {31'd0, e.timeout});
        check({tag, " frozen testnum"}, {1'b0, fail_testnum}, {1'b0, e.testnum});
        check({tag, " frozen cycles"},  cycle_count,          e.cycles);
`ifdef MONITOR_RETIRE_CNT_EN
        check({tag, " frozen retire"},  retire_count,         e.retire);
`endif
    endtask

    task automatic scenario_pass(input string tag);
        do_reset();
        if_pc = IDLE_PC;
        idle(9);                      // edges 1..9
        wb(5'd3, 32'd1);              // edge 10
        idle(9);                      // edges 11..19
        push_exp(1'b1, 1'b0, 1'b0, 31'd0, 24, 1);
        if_pc = END_PC;
        tick();                       // edge 20: enter DRAIN
        if_pc = END_PC + 32'd4;       // leaving END_PC must not abort drain
        idle(3);                      // edges 21..23
        check({tag, " done before verdict"}, {31'd0, done}, 32'd0);
        expect_verdict(tag, 10);
    endtask

    initial begin
        rst     = 1'b0;
        if_pc   = IDLE_PC;
        wb_en   = 1'b0;
        wb_rd   = 5'd0;
        wb_data = 32'd0;

        // Reset state
        do_reset();
        check_cleared("reset");

        // Basic pass
        scenario_pass("pass");

        // Fail: gp=0xB, unrelated writes must not disturb the shadow
        do_reset();
        idle(3);
        wb(5'd3, 32'h0000_000B);      // edge 4
        wb(5'd4, 32'd1);              // edge 5
        wb(5'd0, 32'd1);              // edge 6
        idle(2);                      // edges 7..8
        push_exp(1'b0, 1'b1, 1'b0, 31'd5, 13, 3);
        if_pc = END_PC;
        tick();                       // edge 9
        if_pc = IDLE_PC;
        expect_verdict("fail", 10);

        // Bypass: gp=1 written on the evaluating edge turns fail into pass
        do_reset();
        wb(5'd3, 32'd7);              // edge 1
        idle(4);                      // edges 2..5
        push_exp(1'b1, 1'b0, 1'b0, 31'd0, 10, 2);
        if_pc = END_PC;
        tick();                       // edge 6
        if_pc = IDLE_PC;
        idle(3);                      // edges 7..9
        wb(5'd3, 32'd1);              // edge 10: evaluating edge
        expect_verdict("bypass pass", 2);

        // Bypass the other way: gp=7 on the evaluating edge turns pass into fail
        do_reset();
        wb(5'd3, 32'd1);              // edge 1
        idle(2);                      // edges 2..3
        push_exp(1'b0, 1'b1, 1'b0, 31'd3, 8, 2);
        if_pc = END_PC;
        tick();                       // edge 4
        if_pc = IDLE_PC;
        idle(3);                      // edges 5..7
        wb(5'd3, 32'd7);              // edge 8: evaluating edge
        expect_verdict("bypass fail", 2);

        // Timeout: END_PC never fetched
        do_reset();
        push_exp(1'b0, 1'b0, 1'b1, 31'd0, MAXC, 0);
        expect_verdict("timeout", MAXC + 10);

        // Reset from a terminal state
        rst = 1'b0;
        tick();
        rst = 1'b1;
        cyc = 0;
        check_cleared("reset from done");

        // Reset in the middle of DRAIN, then a clean rerun
        do_reset();
        idle(3);
        if_pc = END_PC;
        tick();                       // edge 4: enter DRAIN
        if_pc = IDLE_PC;
        tick();                       // edge 5: draining
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_cleared("reset mid drain");
        scenario_pass("pass after reset");

        // END_PC on the first cycle after reset; shadow gp must be back to 0
        if_pc = END_PC;
        do_reset();
        push_exp(1'b0, 1'b1, 1'b0, 31'd0, 1 + DRAIN, 0);
        tick();                       // edge 1: enter DRAIN
        if_pc = IDLE_PC;
        expect_verdict("end pc first cycle", 10);

        // Drain completion and budget expiry on the same edge: drain wins
        do_reset();
        wb(5'd3, 32'd1);              // edge 1
        idle(MAXC - DRAIN - 2);       // edges 2..45
        push_exp(1'b1, 1'b0, 1'b0, 31'd0, MAXC, 1);
        if_pc = END_PC;
        tick();                       // edge 46
        if_pc = IDLE_PC;
        expect_verdict("drain beats timeout", 10);

        // Seven writeback pulses, one to x0, before a pass verdict
        do_reset();
        wb(5'd1, 32'h1111);
        wb(5'd0, 32'h2222);
        wb(5'd2, 32'h3333);
        wb(5'd5, 32'h4444);
        wb(5'd3, 32'h0000_0009);
        wb(5'd6, 32'h5555);
        wb(5'd3, 32'd1);              // edge 7
        idle(2);                      // edges 8..9
        push_exp(1'b1, 1'b0, 1'b0, 31'd0, 10 + DRAIN, 7);
        if_pc = END_PC;
        tick();                       // edge 10
        if_pc = IDLE_PC;
        expect_verdict("retire", 10);

        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/test_result_monitor.md
Name: test_result_monitor

Overview:
- Synthesizable end-of-test detector that sits directly downstream of the pipelined Core and consumes its fetch PC and register writeback stream.
- Keeps a shadow copy of x3 (gp) by snooping writebacks.
- Detects arrival at the riscv-tests end PC, waits a fixed number of cycles for the pipeline to drain, then latches pass, fail or timeout.
- Benches and a future FPGA top read one sticky status bus instead of peeking into core internals.

Parameters:
END_PC, 32'h44, fetch PC that marks end of test (pass/fail handler entry)
DRAIN_CYCLES, 4, cycles waited after first END_PC fetch before gp is evaluated; legal range 1..15
MAX_CYCLES, 6000, cycle budget from start of run; reaching it without a verdict means timeout
GP_REG, 5'd3, architectural register index snooped as the test-status register

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-low reset (asserted when 0, sampled on the rising clk edge)
if_pc  in  32  Core fetch-stage PC
wb_en  in  1  Core register-file write enable, writeback stage
wb_rd  in  5  writeback destination register index
wb_data  in  32  writeback data
done  out  1  verdict latched (any of pass/fail/timeout)
pass  out  1  test passed
fail  out  1  test failed
timeout  out  1  cycle budget exhausted
fail_testnum  out  31  gp[31:1] at evaluation; 0 unless fail
cycle_count  out  32  cycles spent in RUN+DRAIN, frozen at verdict

Behaviour:
- Reset (rst==0 at a clk edge): state=RUN; shadow_gp=0; drain_cnt=0; cycle_count=0.
- All outputs 0 during and after reset.
- Reset mid-operation, in any state including DONE: returns to RUN with all cleared on that same edge.
- States:
  - RUN: cycle_count+=1 each cycle. If if_pc==END_PC, go to DRAIN with drain_cnt=0.
  - DRAIN: cycle_count+=1 each cycle; drain_cnt+=1. When drain_cnt==DRAIN_CYCLES-1, evaluate on that edge:
    - If the evaluated gp==1, go to PASS.
    - Otherwise go to FAIL and set fail_testnum=gp[31:1].
    - Drain is committed once entered: if_pc leaving END_PC does not abort it.
  - PASS / FAIL / TIMEOUT: terminal until reset. Outputs and cycle_count are frozen. Writebacks are ignored.
- Timeout: in RUN or DRAIN, when cycle_count==MAX_CYCLES-1 and no verdict is produced on that edge, go to TIMEOUT. cycle_count then reads MAX_CYCLES.
- Simultaneous drain completion and timeout on the same edge: drain verdict wins and timeout stays 0.
- Shadow gp: on any edge in RUN/DRAIN with wb_en==1 and wb_rd==GP_REG, shadow_gp<=wb_data.
  - Writes with wb_rd==0 are ignored even if GP_REG is configured as 0.
- Same-edge writeback and evaluation: evaluation uses wb_data, i.e. the write takes effect first (bypass).
- Output encoding:
  - done = pass|fail|timeout, registered.
  - pass, fail and timeout are one-hot when done==1.
  - Outputs change on the verdict edge and are visible the following cycle (latency 1 from the evaluating edge).
- If if_pc==END_PC on the first cycle after reset, DRAIN is entered on that edge.
- cycle_count does not wrap: MAX_CYCLES < 2^32 is required, and counting stops at a verdict.

Optional Feature:
MONITOR_RETIRE_CNT_EN
- Defined: adds output port retire_count (32 bits).
  - It counts cycles with wb_en==1 while in RUN/DRAIN, and freezes at the verdict.
  - Reset value 0; saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Pass: reset 2 cycles; drive wb_en=1, wb_rd=3, wb_data=1 at cycle 10; if_pc=0x44 at cycle 20 → with DRAIN_CYCLES=4, pass=1, done=1, fail_testnum=0 one cycle after the 4th drain cycle; cycle_count=24.
2. Fail: gp written 0x0000000B, then if_pc=0x44 → fail=1, fail_testnum=5, pass=0.
3. Late gp write: gp=0x7 before END_PC, then gp=1 written on the final drain edge → pass=1, proving the bypass.
4. Timeout: MAX_CYCLES=50; if_pc never equals 0x44 → timeout=1 with cycle_count=50; a later gp=1 write and END_PC fetch cause no change.
5. Reset mid-run: enter DRAIN, pull rst=0 for one edge → all outputs 0 and cycle_count=0; rerunning scenario 1 passes.
6. Retire count (MONITOR_RETIRE_CNT_EN defined): 7 wb_en pulses, including one to x0, before the pass verdict → retire_count=7, frozen after done.
